mux_n_reg: RTL and testbench

Parametrised, registered N-input word multiplexer with a one-entry valid/ready output stage. It generalises the fixed 3-input, 3-bit combinational source mux of the datapath: width and input count are parameters, and the output is a pipeline register. Out-of-range selects produce a defined value and are flagged instead of latching. It sits between the datapath source buses (register file, ALU result, immediate, memory data) and a stalling consumer, for example the register-file write port or the memory address latch.

---
 rtl/mux_n_reg.sv | 81 ++++++++
 tb/tb_mux_n_reg.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_reg.sv
// Registered N-input word mux with a one-entry valid/ready output stage.
// Optional macro MUX_ERRCNT_EN adds the err_count port and its saturating counter.
//
// state | meaning
// EMPTY | out_valid=0, out holds no unconsumed word
// FULL  | out_valid=1, out waits for out_ready
module mux_n_reg #(
   parameter int                 WIDTH       = 16,
   parameter int                 NUM_IN      = 4,
   parameter int                 SEL_W       = 3,
   parameter logic [WIDTH-1:0]   DEFAULT_VAL = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_IN*WIDTH-1:0]   in_flat,
   input  logic [SEL_W-1:0]          control,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sel_err,
`ifdef MUX_ERRCNT_EN
   output logic [7:0]                err_count,
`endif
   input  logic                      err_clr
);

   localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

   logic             accept;
   logic             sel_ok;
   logic [WIDTH-1:0] sel_word;

   // No in_valid term here, so there is no combinational path in_valid -> in_ready.
   assign in_ready = !reset && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign sel_ok   = {1'b0, control} < NUM_IN_W;

   always_comb begin
      sel_word = DEFAULT_VAL;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel_ok && (control == SEL_W'(k)))
            sel_word = in_flat[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         out       <= sel_word;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // err_clr wins over a same-edge out-of-range accept.
   always_ff @(posedge clock) begin
      if (reset)
         sel_err <= 1'b0;
      else if (err_clr)
         sel_err <= 1'b0;
      else if (accept && !sel_ok)
         sel_err <= 1'b1;
   end

`ifdef MUX_ERRCNT_EN
   always_ff @(posedge clock) begin
      if (reset)
         err_count <= 8'd0;
      else if (err_clr)
         err_count <= 8'd0;
      else if (accept && !sel_ok && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed self-checking bench for mux_n_reg (default parameters).
// err_count checks are compiled in only when MUX_ERRCNT_EN is defined.
module tb_mux_n_reg;

   logic        clock;
   logic        reset;
   logic [63:0] in_flat;
   logic [2:0]  control;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready;
   logic        sel_err;
   logic        err_clr;
`ifdef MUX_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   int checks = 0;
   int passes = 0;

   localparam logic [63:0] STD_IN = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

   mux_n_reg dut (
      .clock     (clock),
      .reset     (reset),
      .in_flat   (in_flat),
      .control   (control),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_err   (sel_err),
`ifdef MUX_ERRCNT_EN
      .err_count (err_count),
`endif
      .err_clr   (err_clr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      control = 3'd0; in_flat = STD_IN;
      tick(); tick();
      checks++; if (out !== 16'h0000) $display("FAIL reset_out: got %h want 0000", out); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
      checks++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b want 0", sel_err); else passes++;
      checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passes++;
`ifdef MUX_ERRCNT_EN
      checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", err_count); else passes++;
`endif
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else passes++;
   endtask

   task automatic test_basic();
      control = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out !== 16'h3333) $display("FAIL basic_out: got %h want 3333", out); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", out_valid); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", in_ready); else passes++;
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b want 0", out_valid); else passes++;
   endtask

   task automatic test_backpressure();
      control = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      checks++; if (out !== 16'h1111) $display("FAIL bp_load: got %h want 1111", out); else passes++;
      for (int i = 0; i < 3; i++) begin
         control = 3'(i + 1);
         in_flat = {4{16'(16'hA000 + i)}};
         #1;
         checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); else passes++;
         tick();
         checks++; if (out !== 16'h1111) $display("FAIL bp_hold[%0d]: got %h want 1111", i, out); else passes++;
         checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else passes++;
      end
      in_flat = STD_IN; control = 3'd3; out_ready = 1'b1; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passes++;
      tick();
      checks++; if (out !== 16'h4444) $display("FAIL bp_b2b_out: got %h want 4444", out); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_b2b_valid: got %b want 1", out_valid); else passes++;
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_out_of_range();
      out_ready = 1'b1; control = 3'd5; in_valid = 1'b1;
      tick();
      checks++; if (out !== 16'h0000) $display("FAIL oor_out: got %h want 0000", out); else passes++;
      checks++; if (sel_err !== 1'b1) $display("FAIL oor_sel_err: got %b want 1", sel_err); else passes++;
`ifdef MUX_ERRCNT_EN
      checks++; if (err_count !== 8'd1) $display("FAIL oor_err_count: got %0d want 1", err_count); else passes++;
`endif
      control = 3'd1;
      tick();
      checks++; if (out !== 16'h2222) $display("FAIL oor_next_out: got %h want 2222", out); else passes++;
      checks++; if (sel_err !== 1'b1) $display("FAIL oor_sticky: got %b want 1", sel_err); else passes++;
      in_valid = 1'b0; err_clr = 1'b1; out_ready = 1'b0;
      tick();
      err_clr = 1'b0;
      checks++; if (sel_err !== 1'b0) $display("FAIL oor_clr: got %b want 0", sel_err); else passes++;
      checks++; if (out !== 16'h2222) $display("FAIL oor_clr_out: got %h want 2222", out); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL oor_clr_valid: got %b want 1", out_valid); else passes++;
`ifdef MUX_ERRCNT_EN
      checks++; if (err_count !== 8'd0) $display("FAIL oor_clr_count: got %0d want 0", err_count); else passes++;
`endif
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_saturation();
      out_ready = 1'b1; control = 3'd7; in_valid = 1'b1;
      for (int i = 0; i < 260; i++) tick();
      checks++; if (sel_err !== 1'b1) $display("FAIL sat_sel_err: got %b want 1", sel_err); else passes++;
`ifdef MUX_ERRCNT_EN
      checks++; if (err_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", err_count); else passes++;
`endif
      control = 3'd0;
      tick();
      checks++; if (out !== 16'h1111) $display("FAIL sat_valid_sel: got %h want 1111", out); else passes++;
      control = 3'd6; err_clr = 1'b1;
      tick();
      err_clr = 1'b0; in_valid = 1'b0;
      checks++; if (sel_err !== 1'b0) $display("FAIL prio_sel_err: got %b want 0", sel_err); else passes++;
      checks++; if (out !== 16'h0000) $display("FAIL prio_out: got %h want 0000", out); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL prio_valid: got %b want 1", out_valid); else passes++;
`ifdef MUX_ERRCNT_EN
      checks++; if (err_count !== 8'd0) $display("FAIL prio_count: got %0d want 0", err_count); else passes++;
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1; in_valid = 1'b1; control = 3'd5;
      tick();
      control = 3'd1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      tick();
      checks++; if (out !== 16'h2222) $display("FAIL rmid_pre_out: got %h want 2222", out); else passes++;
      checks++; if (sel_err !== 1'b1) $display("FAIL rmid_pre_err: got %b want 1", sel_err); else passes++;
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL rmid_ready_during: got %b want 0", in_ready); else passes++;
      tick();
      checks++; if (out !== 16'h0000) $display("FAIL rmid_out: got %h want 0000", out); else passes++;
      checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", out_valid); else passes++;
      checks++; if (sel_err !== 1'b0) $display("FAIL rmid_sel_err: got %b want 0", sel_err); else passes++;
      reset = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready_after: got %b want 1", in_ready); else passes++;
   endtask

   task automatic test_streaming();
      logic [15:0] exp_word [4];
      exp_word[0] = 16'h1111; exp_word[1] = 16'h2222;
      exp_word[2] = 16'h3333; exp_word[3] = 16'h4444;
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         control = 3'(i % 4);
         tick();
         checks++; if (out !== exp_word[i % 4]) $display("FAIL stream_out[%0d]: got %h want %h", i, out, exp_word[i % 4]); else passes++;
         checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); else passes++;
      end
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_out_of_range();
      test_saturation();
      test_reset_mid();
      test_streaming();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
